// File: rtl/jtcps1_cfg_tx_pkg.sv
// Shared constants and FSM encoding for the CPS-B configuration transmitter.
package jtcps1_cfg_tx_pkg;

  localparam int DEF_REGSIZE = 24;
  localparam int DEF_GAP     = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CAPTURE  = 3'd1,
    ST_SEND     = 3'd2,
    ST_GAP_WAIT = 3'd3,
    ST_DONE     = 3'd4
  } cfg_st_e;

endpackage

// File: rtl/jtcps1_cfg_tx_if.sv
// Download-side and MMR-chain-side signals of the configuration transmitter.
interface jtcps1_cfg_tx_if;

  logic        downloading;
  logic [21:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic        resend;
  logic        cfg_we;
  logic [7:0]  cfg_data;
  logic        cfg_done;
  logic        cfg_err;

  modport master (
    output downloading, ioctl_addr, ioctl_data, ioctl_wr, resend,
    input  cfg_we, cfg_data, cfg_done, cfg_err
  );

  modport slave (
    input  downloading, ioctl_addr, ioctl_data, ioctl_wr, resend,
    output cfg_we, cfg_data, cfg_done, cfg_err
  );

endinterface

// File: rtl/jtcps1_cfg_tx.sv
// Captures the CPS-B configuration bytes from the ROM download and shifts
// them, byte 0 first, into the MMR configuration chain.
//
// state       | meaning
// ST_IDLE     | nothing captured since reset
// ST_CAPTURE  | download running, buffer accepts window writes
// ST_SEND     | drive one cfg_we pulse with buffer[idx]
// ST_GAP_WAIT | idle clocks between pulses
// ST_DONE     | chain loaded, resend allowed
module jtcps1_cfg_tx
  import jtcps1_cfg_tx_pkg::*;
#(
  parameter int          REGSIZE   = DEF_REGSIZE,
  parameter logic [21:0] CFG_START = 22'h0,
  parameter int          GAP       = DEF_GAP
) (
  input  logic            clk,
  input  logic            rst,
  jtcps1_cfg_tx_if.slave  bus
);

  localparam int             IW       = (REGSIZE > 1) ? $clog2(REGSIZE) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(REGSIZE - 1);
  localparam logic [3:0]     GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  logic [7:0]         buffer [REGSIZE];
  logic [REGSIZE-1:0] seen;
  cfg_st_e            st, st_nx;
  logic [IW-1:0]      idx, idx_nx;
  logic [3:0]         gap_cnt, gap_nx;
  logic               err_q, err_nx;
  logic               dl_q;
  logic               dl_rise, dl_fall;
  logic [21:0]        off;
  logic               in_win, wr_en;
  logic               we;

  assign dl_rise = bus.downloading & ~dl_q;
  assign dl_fall = ~bus.downloading & dl_q;

  // Addresses below CFG_START wrap to large offsets and fall outside the window
  assign off    = bus.ioctl_addr - CFG_START;
  assign in_win = off < 22'(REGSIZE);
  assign wr_en  = (st == ST_CAPTURE) && bus.downloading && bus.ioctl_wr && in_win && !rst;

  always_comb begin
    st_nx  = st;
    idx_nx = idx;
    gap_nx = gap_cnt;
    err_nx = err_q;
    we     = 1'b0;
    case (st)
      ST_IDLE: begin
        if (dl_rise) st_nx = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (dl_fall) begin
          st_nx  = ST_SEND;
          idx_nx = '0;
          gap_nx = '0;
          err_nx = ~&seen;
        end
      end
      ST_SEND: begin
        if (dl_rise) begin
          st_nx = ST_CAPTURE;
        end else begin
          we = 1'b1;
          if (idx == LAST_IDX) begin
            st_nx = ST_DONE;
          end else begin
            idx_nx = idx + IW'(1);
            if (GAP != 0) begin
              st_nx  = ST_GAP_WAIT;
              gap_nx = GAP_LOAD;
            end
          end
        end
      end
      ST_GAP_WAIT: begin
        if (dl_rise)           st_nx = ST_CAPTURE;
        else if (gap_cnt == 0) st_nx = ST_SEND;
        else                   gap_nx = gap_cnt - 4'd1;
      end
      ST_DONE: begin
        if (dl_rise) begin
          st_nx = ST_CAPTURE;
        end else if (bus.resend) begin
          st_nx  = ST_SEND;
          idx_nx = '0;
        end
      end
      default: st_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= ST_IDLE;
      idx     <= '0;
      gap_cnt <= '0;
      err_q   <= 1'b0;
      dl_q    <= 1'b0;
      seen    <= '0;
    end else begin
      st      <= st_nx;
      idx     <= idx_nx;
      gap_cnt <= gap_nx;
      err_q   <= err_nx;
      dl_q    <= bus.downloading;
      if (dl_rise)    seen <= '0;
      else if (wr_en) seen[off[IW-1:0]] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buffer[off[IW-1:0]] <= bus.ioctl_data;
  end

  // Outputs are gated by rst and dl_rise so both take effect in the same cycle
  assign bus.cfg_we   = we & ~rst;
  assign bus.cfg_data = (we && !rst && seen[idx]) ? buffer[idx] : 8'h00;
  assign bus.cfg_done = (st == ST_DONE) && !dl_rise && !rst;
  assign bus.cfg_err  = err_q;

endmodule

// File: tb/tb_jtcps1_cfg_tx.sv
// Scoreboard bench: stimulus queues expected cfg bytes, monitors pop and compare on cfg_we.
module tb_jtcps1_cfg_tx;
  import jtcps1_cfg_tx_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    bit         first;
    bit         last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   en0 = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pulses1 = 0, pulses0 = 0;
  int   last1 = 0, last0 = 0;
  exp_t q1[$];
  exp_t q0[$];
  logic [7:0] mmr [24];

  logic [7:0] pat_a [24] = '{8'h20, 8'h05, 8'hFF, 8'h3C, 8'h81, 8'h00, 8'h7E, 8'h11,
                             8'h42, 8'h99, 8'hC3, 8'h18, 8'hE7, 8'h24, 8'hDB, 8'h66,
                             8'h0F, 8'hF0, 8'hA5, 8'h5A, 8'h33, 8'hCC, 8'h01, 8'h80};
  logic [7:0] pat_b [24] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                             8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10,
                             8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
  logic [7:0] pat_c [24] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hE4, 8'hF5, 8'h06, 8'h17,
                             8'h28, 8'h39, 8'h4A, 8'h5B, 8'h6C, 8'h7D, 8'h8E, 8'h9F,
                             8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h76, 8'h54, 8'h32, 8'h10};

  jtcps1_cfg_tx_if bus ();
  jtcps1_cfg_tx_if bus0 ();

  assign bus0.downloading = en0 & bus.downloading;
  assign bus0.ioctl_addr  = bus.ioctl_addr;
  assign bus0.ioctl_data  = bus.ioctl_data;
  assign bus0.ioctl_wr    = en0 & bus.ioctl_wr;
  assign bus0.resend      = en0 & bus.resend;

  jtcps1_cfg_tx #(.REGSIZE(24), .CFG_START(22'h0), .GAP(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  jtcps1_cfg_tx #(.REGSIZE(24), .CFG_START(22'h0), .GAP(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // GAP=2 monitor, also models the MMR shift chain
  always @(negedge clk) begin
    exp_t e;
    if (bus.cfg_we === 1'b1) begin
      pulses1++;
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got cfg_data %0h expected no pulse (cycle %0d)", bus.cfg_data, cyc);
      end else begin
        e = q1.pop_front();
        chk("cfg_data", bus.cfg_data, e.d);
        if (!e.first) chk("pulse_spacing", cyc - last1, 3);
        if (e.last)   chk("done_at_last_pulse", bus.cfg_done, 0);
      end
      for (int i = 0; i < 23; i++) mmr[i] = mmr[i+1];
      mmr[23] = bus.cfg_data;
      last1 = cyc;
    end else begin
      chk("idle_data", bus.cfg_data, 0);
    end
  end

  // GAP=0 monitor
  always @(negedge clk) begin
    exp_t e;
    if (bus0.cfg_we === 1'b1) begin
      pulses0++;
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse_gap0: got cfg_data %0h expected no pulse (cycle %0d)", bus0.cfg_data, cyc);
      end else begin
        e = q0.pop_front();
        chk("cfg_data_gap0", bus0.cfg_data, e.d);
        if (!e.first) chk("pulse_spacing_gap0", cyc - last0, 1);
      end
      last0 = cyc;
    end
  end

  task automatic push_exp(input logic [7:0] p [24], input int skip);
    exp_t e;
    for (int i = 0; i < 24; i++) begin
      e.d     = (i == skip) ? 8'h00 : p[i];
      e.first = (i == 0);
      e.last  = (i == 23);
      q1.push_back(e);
      if (en0) q0.push_back(e);
    end
    pulses1 = 0;
    pulses0 = 0;
  endtask

  task automatic dl_start();
    @(posedge clk); #1;
    bus.downloading = 1'b1;
    @(negedge clk);
    chk("done_drop_on_download", bus.cfg_done, 0);
    @(posedge clk); #1;
  endtask

  task automatic dl_bytes(input logic [7:0] p [24], input int skip);
    for (int i = 0; i < 24; i++) begin
      if (i != skip) begin
        bus.ioctl_addr = 22'(i);
        bus.ioctl_data = p[i];
        bus.ioctl_wr   = 1'b1;
        @(posedge clk); #1;
        bus.ioctl_wr   = 1'b0;
        @(posedge clk); #1;
      end
    end
    // Writes outside the configuration window
    bus.ioctl_addr = 22'd24;
    bus.ioctl_data = 8'hAA;
    bus.ioctl_wr   = 1'b1;
    @(posedge clk); #1;
    bus.ioctl_addr = 22'h3FFFFF;
    bus.ioctl_data = 8'h55;
    @(posedge clk); #1;
    bus.ioctl_wr   = 1'b0;
  endtask

  task automatic dl_end(input logic [7:0] p [24], input int skip);
    push_exp(p, skip);
    bus.downloading = 1'b0;
  endtask

  task automatic wait_pulses(input int n);
    int t = 0;
    while (pulses1 < n && t < 2000) begin
      @(posedge clk);
      t++;
    end
    chk("wait_pulses_reached", 32'(pulses1 >= n), 1);
    #1;
  endtask

  task automatic drain();
    int t = 0;
    while ((q1.size() != 0 || q0.size() != 0) && t < 2000) begin
      @(posedge clk);
      t++;
    end
    chk("drain_queue_empty", 32'(q1.size() + q0.size()), 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.downloading = 1'b0;
    bus.ioctl_addr  = '0;
    bus.ioctl_data  = '0;
    bus.ioctl_wr    = 1'b0;
    bus.resend      = 1'b0;
    for (int i = 0; i < 24; i++) mmr[i] = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cfg_we", bus.cfg_we, 0);
    chk("reset_cfg_data", bus.cfg_data, 0);
    chk("reset_cfg_done", bus.cfg_done, 0);
    chk("reset_cfg_err", bus.cfg_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full download, 24 pulses 3 cycles apart
    dl_start();
    dl_bytes(pat_a, -1);
    dl_end(pat_a, -1);
    drain();
    chk("full_done", bus.cfg_done, 1);
    chk("full_err", bus.cfg_err, 0);
    chk("full_count", pulses1, 24);
    for (int i = 0; i < 24; i++) chk("mmr_chain", mmr[i], pat_a[i]);

    // Stray write outside download must not alter the buffer
    @(posedge clk); #1;
    bus.ioctl_addr = 22'd0;
    bus.ioctl_data = 8'h77;
    bus.ioctl_wr   = 1'b1;
    @(posedge clk); #1;
    bus.ioctl_wr   = 1'b0;

    // Resend in DONE replays, resend during SEND is ignored
    push_exp(pat_a, -1);
    bus.resend = 1'b1;
    @(posedge clk); #1;
    bus.resend = 1'b0;
    wait_pulses(3);
    bus.resend = 1'b1;
    @(posedge clk); #1;
    bus.resend = 1'b0;
    drain();
    chk("resend_done", bus.cfg_done, 1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("resend_count", pulses1, 24);

    // Download missing index 7
    dl_start();
    dl_bytes(pat_b, 7);
    dl_end(pat_b, 7);
    drain();
    chk("omit_err", bus.cfg_err, 1);
    chk("omit_done", bus.cfg_done, 1);
    chk("omit_count", pulses1, 24);

    // Download restarted in the SEND cycle after pulse 10
    dl_start();
    dl_bytes(pat_a, -1);
    dl_end(pat_a, -1);
    wait_pulses(10);
    repeat (2) @(posedge clk);
    #1;
    bus.downloading = 1'b1;
    q1.delete();
    @(negedge clk);
    chk("abort_cfg_we", bus.cfg_we, 0);
    chk("abort_done", bus.cfg_done, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_count", pulses1, 10);
    dl_bytes(pat_c, -1);
    dl_end(pat_c, -1);
    drain();
    chk("restart_done", bus.cfg_done, 1);
    chk("restart_err", bus.cfg_err, 0);
    chk("restart_count", pulses1, 24);
    for (int i = 0; i < 24; i++) chk("mmr_restart", mmr[i], pat_c[i]);

    // Reset in the SEND cycle after pulse 5
    dl_start();
    dl_bytes(pat_a, -1);
    dl_end(pat_a, -1);
    wait_pulses(5);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    q1.delete();
    @(negedge clk);
    chk("rst_cfg_we_same", bus.cfg_we, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cfg_we_next", bus.cfg_we, 0);
    chk("rst_done", bus.cfg_done, 0);
    chk("rst_err", bus.cfg_err, 0);
    @(posedge clk); #1;
    bus.resend = 1'b1;
    @(posedge clk); #1;
    bus.resend = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("rst_count", pulses1, 5);

    // GAP=0 instance: back-to-back pulses
    en0 = 1'b1;
    dl_start();
    dl_bytes(pat_c, -1);
    dl_end(pat_c, -1);
    drain();
    chk("gap0_count", pulses0, 24);
    chk("gap0_done", bus0.cfg_done, 1);
    chk("gap0_err", bus0.cfg_err, 0);
    chk("gap2_count", pulses1, 24);
    chk("gap2_done", bus.cfg_done, 1);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtcps1_cfg_tx.md
JTCPS1_CFG_TX -- requirements
Module: jtcps1_cfg_tx

Interface
REQ-001 SHALL have parameter REGSIZE, default 24, meaning number of CPS-B configuration bytes in the register chain.
REQ-002 SHALL have parameter CFG_START, default 22'h0, meaning download address of configuration byte 0.
REQ-003 SHALL have parameter GAP, default 2, meaning idle clocks between consecutive cfg_we pulses (range 0..15).
REQ-004 SHALL have port clk  input  1  system clock; the block has one clock only.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port downloading  input  1  ROM download in progress.
REQ-007 SHALL have port ioctl_addr  input  22  download byte address.
REQ-008 SHALL have port ioctl_data  input  8  download byte.
REQ-009 SHALL have port ioctl_wr  input  1  one-cycle download byte strobe.
REQ-010 SHALL have port resend  input  1  pulse requesting replay of the stored configuration.
REQ-011 SHALL have port cfg_we  output  1  shift strobe to the MMR configuration chain.
REQ-012 SHALL have port cfg_data  output  8  configuration byte, valid while cfg_we=1.
REQ-013 SHALL have port cfg_done  output  1  full chain loaded, level.
REQ-014 SHALL have port cfg_err  output  1  last download did not supply all REGSIZE bytes.

Function
REQ-015 SHALL keep a REGSIZE x 8 buffer written when ioctl_wr=1, downloading=1 and CFG_START <= ioctl_addr < CFG_START+REGSIZE, at index ioctl_addr-CFG_START.
REQ-016 SHALL track one "seen" bit per index; the bits clear on the rising edge of downloading.
REQ-017 SHALL use FSM states IDLE, CAPTURE, SEND, GAP_WAIT, DONE.
REQ-018 SHALL transition IDLE/DONE -> CAPTURE on the rising edge of downloading; cfg_done drops to 0 in the same cycle.
REQ-019 SHALL transition CAPTURE -> SEND on the falling edge of downloading; cfg_err is set to 1 if any seen bit is 0, else cleared.
REQ-020 SHALL emit, in SEND, cfg_we=1 for exactly one cycle with cfg_data=buffer[idx], starting at idx=0 and ascending, so that byte 0 ends in chain position 0 after REGSIZE shifts.
REQ-021 SHALL send buffer entries never written as 8'h00.
REQ-022 SHALL, after each pulse, enter GAP_WAIT for GAP cycles (GAP=0: next pulse on next cycle), then return to SEND; after idx=REGSIZE-1, go to DONE and set cfg_done=1 one cycle after the last pulse.
REQ-023 SHALL, on resend=1 in DONE, replay all REGSIZE bytes unchanged via SEND; resend is ignored in all other states.
REQ-024 SHALL, if downloading rises during SEND/GAP_WAIT, abort immediately (no further cfg_we), go to CAPTURE and restart from idx=0 after the download.
REQ-025 SHALL ignore ioctl_wr outside CAPTURE and when downloading=0; addresses outside the window never alter the buffer.
REQ-026 SHALL hold cfg_data at 8'h00 whenever cfg_we=0.
REQ-027 SHALL emit exactly REGSIZE pulses per completed transfer, with no pulses in IDLE, CAPTURE or DONE.

Reset
REQ-028 SHALL, on rst=1 at a clk edge, enter IDLE with cfg_we=0, cfg_data=8'h00, cfg_done=0, cfg_err=0, idx=0, gap counter=0 and all seen bits clear; buffer contents are not reset.
REQ-029 SHALL take precedence for rst over every other input in the same cycle; rst mid-SEND stops the transfer with no further pulses.

Structure
REQ-030 SHALL place the FSM state encoding and the default REGSIZE/GAP constants in a shared jtcps1 package.
REQ-031 SHALL be a single module with no sub-modules; the buffer is a plain register array.

Verification
REQ-032 SHALL cover full download of bytes 0x20,0x05,0xFF... (24 bytes, CFG_START=0) -> 24 cfg_we pulses, 3 cycles apart, in address order; cfg_done=1; cfg_err=0; captured MMR regs match.
REQ-033 SHALL cover a download omitting index 7 -> cfg_err=1 and pulse 8 carries 8'h00.
REQ-034 SHALL cover resend pulse in DONE -> identical 24-byte sequence; resend during SEND -> ignored, count stays 24.
REQ-035 SHALL cover downloading rising after pulse 10 -> pulses stop at once; after a second download completes -> 24 fresh pulses from idx 0.
REQ-036 SHALL cover rst asserted mid-SEND -> cfg_we=0 on the next cycle, state IDLE, cfg_done=0, and no pulses until the next download.
REQ-037 SHALL cover GAP=0 -> 24 back-to-back cfg_we cycles.
